// File: rtl/cnn_tb_pkg.sv
// ============================================================================
// Module      : cnn_tb_pkg
// Description : Shared error codes, monitor FSM states and IEEE-754 ordinal
//               helpers for the CNN output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_tb_pkg;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_IDLE_OUT  = 3'd1;
    localparam logic [2:0] ERR_OVERLAP   = 3'd2;
    localparam logic [2:0] ERR_LATENCY   = 3'd3;
    localparam logic [2:0] ERR_SHORT     = 3'd4;
    localparam logic [2:0] ERR_EARLY_OUT = 3'd5;
    localparam logic [2:0] ERR_MISMATCH  = 3'd6;
    localparam logic [2:0] ERR_NO_GOLD   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INPUT  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_OUTPUT = 2'd3
    } mon_state_e;

    // Sign-magnitude to two's-complement ordinal; +0 and -0 both map to 0.
    function automatic logic signed [64:0] fp_ord(input logic [63:0] x, input int unsigned w);
        logic [63:0] sign_mask;
        logic [63:0] mag;
        sign_mask = 64'd1 << (w - 1);
        mag       = x & (sign_mask - 64'd1);
        if ((x & sign_mask) != 64'd0)
            return -$signed({1'b0, mag});
        else
            return $signed({1'b0, mag});
    endfunction

    // Exponent width follows the IEEE-754 binary16/32/64 layouts.
    function automatic logic fp_is_nan(input logic [63:0] x, input int unsigned w);
        int unsigned ew;
        int unsigned mw;
        logic [63:0] exp_mask;
        logic [63:0] man_mask;
        ew       = (w == 16) ? 5 : ((w == 64) ? 11 : 8);
        mw       = w - 1 - ew;
        man_mask = (64'd1 << mw) - 64'd1;
        exp_mask = ((64'd1 << ew) - 64'd1) << mw;
        return ((x & exp_mask) == exp_mask) && ((x & man_mask) != 64'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cnn_gold_fifo.sv
// ============================================================================
// Module      : cnn_gold_fifo
// Description : Synchronous show-ahead FIFO holding golden output words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_gold_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int c_AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_AW + 1;

    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign empty     = (r_count == '0);
    assign rd_data   = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a push into a full queue still lands.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)
                r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push)
                r_count <= r_count - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cnn_out_monitor.sv
// ============================================================================
// Module      : cnn_out_monitor
// Description : Protocol and golden-value checker watching a CNN DUT's pins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_out_monitor
    import cnn_tb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int OUT_NUM    = 1,
    parameter int MAX_LAT    = 1000,
    parameter int FIFO_DEPTH = 8,
    parameter int FP_CMP     = 1,
    parameter int TOL_ULP    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              out_valid,
    input  logic [DATA_W-1:0] out,
    input  logic              gold_valid,
    input  logic [DATA_W-1:0] gold_data,
    output logic              gold_full,
    output logic              err_valid,
    output logic [2:0]        err_code,
    output logic              pat_done,
    output logic [15:0]       pat_cnt,
    output logic [15:0]       fail_cnt
);

    localparam int                 c_LAT_W     = $clog2(MAX_LAT + 1);
    localparam logic [c_LAT_W-1:0] c_LAT_LAST  = c_LAT_W'(MAX_LAT - 1);
    localparam logic [7:0]         c_WORD_LAST = 8'(OUT_NUM - 1);

    mon_state_e         r_state;
    mon_state_e         w_next_state;
    logic [c_LAT_W-1:0] r_lat;
    logic [7:0]         r_word_cnt;
    logic               r_err_valid;
    logic [2:0]         r_err_code;
    logic               r_pat_done;
    logic [15:0]        r_pat_cnt;
    logic [15:0]        r_fail_cnt;

    logic [7:1]         w_flags;
    logic [2:0]         w_err_code;
    logic               w_take;
    logic               w_pop;
    logic               w_pat_done;
    logic               w_lat_clr;
    logic               w_lat_inc;
    logic               w_mismatch;
    logic [DATA_W-1:0]  w_gold;
    logic               w_gold_empty;

    cnn_gold_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_gold_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (gold_valid),
        .push_data (gold_data),
        .pop       (w_pop),
        .rd_data   (w_gold),
        .full      (gold_full),
        .empty     (w_gold_empty)
    );

    generate
        if (FP_CMP != 0) begin : g_fp_cmp
            logic [63:0]        w_out64;
            logic [63:0]        w_gold64;
            logic signed [64:0] w_diff;
            logic [64:0]        w_dist;
            logic               w_out_nan;
            logic               w_gold_nan;

            assign w_out64    = 64'(out);
            assign w_gold64   = 64'(w_gold);
            assign w_diff     = fp_ord(w_out64, DATA_W) - fp_ord(w_gold64, DATA_W);
            assign w_dist     = w_diff[64] ? $unsigned(-w_diff) : $unsigned(w_diff);
            assign w_out_nan  = fp_is_nan(w_out64, DATA_W);
            assign w_gold_nan = fp_is_nan(w_gold64, DATA_W);
            assign w_mismatch = (w_out_nan && w_gold_nan) ? 1'b0 :
                                (w_out_nan || w_gold_nan) ? 1'b1 :
                                (w_dist > 65'(TOL_ULP));
        end else begin : g_exact_cmp
            assign w_mismatch = (out != w_gold);
        end
    endgenerate

    always_comb begin
        w_next_state = r_state;
        w_flags      = '0;
        w_take       = 1'b0;
        w_pop        = 1'b0;
        w_pat_done   = 1'b0;
        w_lat_clr    = 1'b0;
        w_lat_inc    = 1'b0;

        w_flags[ERR_IDLE_OUT] = !out_valid && (out != '0);
        w_flags[ERR_OVERLAP]  = in_valid && out_valid;

        case (r_state)
            ST_IDLE: begin
                w_flags[ERR_EARLY_OUT] = out_valid;
                if (in_valid)
                    w_next_state = ST_INPUT;
            end
            ST_INPUT: begin
                w_flags[ERR_EARLY_OUT] = out_valid;
                if (!in_valid) begin
                    w_next_state = ST_WAIT;
                    w_lat_clr    = 1'b1;
                end
            end
            ST_WAIT: begin
                if (out_valid) begin
                    w_take = 1'b1;
                end else if (r_lat == c_LAT_LAST) begin
                    w_flags[ERR_LATENCY] = 1'b1;
                    w_next_state         = ST_IDLE;
                end else begin
                    w_lat_inc = 1'b1;
                end
            end
            ST_OUTPUT: begin
                if (out_valid) begin
                    w_take = 1'b1;
                end else begin
                    w_flags[ERR_SHORT] = 1'b1;
                    w_next_state       = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase

        // The first word can arrive while still in WAIT; it counts toward the burst.
        if (w_take) begin
            if (w_gold_empty) begin
                w_flags[ERR_NO_GOLD] = 1'b1;
            end else begin
                w_pop                 = 1'b1;
                w_flags[ERR_MISMATCH] = w_mismatch;
            end
            if (r_word_cnt == c_WORD_LAST) begin
                w_next_state = ST_IDLE;
                w_pat_done   = 1'b1;
            end else begin
                w_next_state = ST_OUTPUT;
            end
        end
    end

    always_comb begin
        w_err_code = ERR_NONE;
        if (w_flags[ERR_NO_GOLD])        w_err_code = ERR_NO_GOLD;
        else if (w_flags[ERR_MISMATCH])  w_err_code = ERR_MISMATCH;
        else if (w_flags[ERR_EARLY_OUT]) w_err_code = ERR_EARLY_OUT;
        else if (w_flags[ERR_SHORT])     w_err_code = ERR_SHORT;
        else if (w_flags[ERR_LATENCY])   w_err_code = ERR_LATENCY;
        else if (w_flags[ERR_OVERLAP])   w_err_code = ERR_OVERLAP;
        else if (w_flags[ERR_IDLE_OUT])  w_err_code = ERR_IDLE_OUT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_lat       <= '0;
            r_word_cnt  <= '0;
            r_err_valid <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_pat_done  <= 1'b0;
            r_pat_cnt   <= '0;
            r_fail_cnt  <= '0;
        end else begin
            r_state <= w_next_state;

            if (w_lat_clr)
                r_lat <= '0;
            else if (w_lat_inc)
                r_lat <= r_lat + 1'b1;

            if (w_next_state == ST_IDLE)
                r_word_cnt <= '0;
            else if (w_take)
                r_word_cnt <= r_word_cnt + 1'b1;

            r_err_valid <= |w_flags;
            if (|w_flags)
                r_err_code <= w_err_code;

            r_pat_done <= w_pat_done;
            if (w_pat_done)
                r_pat_cnt <= r_pat_cnt + 1'b1;

            if (w_flags[ERR_MISMATCH] && (r_fail_cnt != 16'hFFFF))
                r_fail_cnt <= r_fail_cnt + 1'b1;
        end
    end

    assign err_valid = r_err_valid;
    assign err_code  = r_err_code;
    assign pat_done  = r_pat_done;
    assign pat_cnt   = r_pat_cnt;
    assign fail_cnt  = r_fail_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cnn_out_monitor.sv
// ============================================================================
// Module      : tb_cnn_out_monitor
// Description : Directed bench for cnn_out_monitor across three parameter sets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnn_out_monitor;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // Instance A: default parameters
    logic        a_in_valid, a_out_valid, a_gold_valid;
    logic [31:0] a_out, a_gold_data;
    logic        a_gold_full, a_err_valid, a_pat_done;
    logic [2:0]  a_err_code;
    logic [15:0] a_pat_cnt, a_fail_cnt;

    // Instance B: OUT_NUM=4
    logic        b_in_valid, b_out_valid, b_gold_valid;
    logic [31:0] b_out, b_gold_data;
    logic        b_gold_full, b_err_valid, b_pat_done;
    logic [2:0]  b_err_code;
    logic [15:0] b_pat_cnt, b_fail_cnt;

    // Instance C: FIFO_DEPTH=2, OUT_NUM=3
    logic        c_in_valid, c_out_valid, c_gold_valid;
    logic [31:0] c_out, c_gold_data;
    logic        c_gold_full, c_err_valid, c_pat_done;
    logic [2:0]  c_err_code;
    logic [15:0] c_pat_cnt, c_fail_cnt;

    cnn_out_monitor u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .out_valid(a_out_valid),
        .out(a_out), .gold_valid(a_gold_valid), .gold_data(a_gold_data),
        .gold_full(a_gold_full), .err_valid(a_err_valid), .err_code(a_err_code),
        .pat_done(a_pat_done), .pat_cnt(a_pat_cnt), .fail_cnt(a_fail_cnt)
    );

    cnn_out_monitor #(.OUT_NUM(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .out_valid(b_out_valid),
        .out(b_out), .gold_valid(b_gold_valid), .gold_data(b_gold_data),
        .gold_full(b_gold_full), .err_valid(b_err_valid), .err_code(b_err_code),
        .pat_done(b_pat_done), .pat_cnt(b_pat_cnt), .fail_cnt(b_fail_cnt)
    );

    cnn_out_monitor #(.FIFO_DEPTH(2), .OUT_NUM(3)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .out_valid(c_out_valid),
        .out(c_out), .gold_valid(c_gold_valid), .gold_data(c_gold_data),
        .gold_full(c_gold_full), .err_valid(c_err_valid), .err_code(c_err_code),
        .pat_done(c_pat_done), .pat_cnt(c_pat_cnt), .fail_cnt(c_fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One single-word pattern on instance A: push gold, 9 input cycles, wait, one output word.
    task automatic a_pattern(input logic [31:0] g, input logic [31:0] o, input int wait_n);
        a_gold_valid = 1'b1; a_gold_data = g;
        tick();
        a_gold_valid = 1'b0;
        a_in_valid   = 1'b1;
        repeat (9) tick();
        a_in_valid = 1'b0;
        tick();
        repeat (wait_n) tick();
        a_out_valid = 1'b1; a_out = o;
        tick();
        a_out_valid = 1'b0; a_out = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        {a_in_valid, a_out_valid, a_gold_valid} = '0; a_out = '0; a_gold_data = '0;
        {b_in_valid, b_out_valid, b_gold_valid} = '0; b_out = '0; b_gold_data = '0;
        {c_in_valid, c_out_valid, c_gold_valid} = '0; c_out = '0; c_gold_data = '0;
        #2;
        chk("rst_err_valid", 32'(a_err_valid), 32'd0);
        chk("rst_err_code",  32'(a_err_code),  32'd0);
        chk("rst_pat_cnt",   32'(a_pat_cnt),   32'd0);
        chk("rst_fail_cnt",  32'(a_fail_cnt),  32'd0);
        chk("rst_gold_full", 32'(a_gold_full), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Within tolerance (1 ULP)
        a_pattern(32'h3F800000, 32'h3F800001, 4);
        chk("t1_pat_done",  32'(a_pat_done),  32'd1);
        chk("t1_err_valid", 32'(a_err_valid), 32'd0);
        chk("t1_pat_cnt",   32'(a_pat_cnt),   32'd1);
        tick();
        chk("t1_pat_done_pulse", 32'(a_pat_done), 32'd0);

        // Beyond tolerance (3 ULP)
        a_pattern(32'h3F800000, 32'h3F800003, 4);
        chk("t2_err_valid", 32'(a_err_valid), 32'd1);
        chk("t2_err_code",  32'(a_err_code),  32'd6);
        chk("t2_fail_cnt",  32'(a_fail_cnt),  32'd1);
        chk("t2_pat_done",  32'(a_pat_done),  32'd1);
        tick();
        chk("t2_err_pulse", 32'(a_err_valid), 32'd0);
        chk("t2_code_held", 32'(a_err_code),  32'd6);

        // -0 against +0, NaN against NaN, NaN against adjacent infinity
        a_pattern(32'h80000000, 32'h00000000, 2);
        chk("zero_err_valid", 32'(a_err_valid), 32'd0);
        a_pattern(32'h7FC00000, 32'h7FFFFFFF, 2);
        chk("nan_nan_err_valid", 32'(a_err_valid), 32'd0);
        a_pattern(32'h7F800000, 32'h7F800001, 2);
        chk("inf_nan_err_code", 32'(a_err_code), 32'd6);
        chk("inf_nan_fail_cnt", 32'(a_fail_cnt), 32'd2);
        chk("a_pat_cnt_5",      32'(a_pat_cnt),  32'd5);
        tick();

        // Non-zero out while idle
        a_out = 32'h00000001;
        tick();
        chk("idle_out_err_valid", 32'(a_err_valid), 32'd1);
        chk("idle_out_err_code",  32'(a_err_code),  32'd1);
        a_out = '0;
        tick();
        chk("idle_out_clear", 32'(a_err_valid), 32'd0);

        // Latency timeout: the 1000th WAIT cycle flags
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick();
        repeat (999) tick();
        chk("lat_999_no_err", 32'(a_err_valid), 32'd0);
        tick();
        chk("lat_err_valid", 32'(a_err_valid), 32'd1);
        chk("lat_err_code",  32'(a_err_code),  32'd3);
        chk("lat_pat_done",  32'(a_pat_done),  32'd0);
        chk("lat_pat_cnt",   32'(a_pat_cnt),   32'd5);
        a_out_valid = 1'b1;
        tick();
        chk("lat_back_idle", 32'(a_err_code), 32'd5);
        a_out_valid = 1'b0;
        tick();

        // B: short burst (3 of 4), with an overlapping in_valid on the third word
        b_gold_valid = 1'b1;
        b_gold_data = 32'h40000000; tick();
        b_gold_data = 32'h40400000; tick();
        b_gold_data = 32'h40800000; tick();
        b_gold_data = 32'h40A00000; tick();
        b_gold_valid = 1'b0;
        b_in_valid = 1'b1; tick();
        b_in_valid = 1'b0; tick();
        b_out_valid = 1'b1;
        b_out = 32'h40000000; tick();
        b_out = 32'h40400000; tick();
        chk("b_burst_ok", 32'(b_err_valid), 32'd0);
        b_in_valid = 1'b1;
        b_out = 32'h40800000; tick();
        chk("b_overlap_code", 32'(b_err_code), 32'd2);
        b_in_valid = 1'b0; b_out_valid = 1'b0; b_out = '0;
        tick();
        chk("b_short_err_valid", 32'(b_err_valid), 32'd1);
        chk("b_short_err_code",  32'(b_err_code),  32'd4);
        chk("b_short_pat_done",  32'(b_pat_done),  32'd0);
        chk("b_short_pat_cnt",   32'(b_pat_cnt),   32'd0);

        // B: reset mid-OUTPUT using the leftover gold word
        b_in_valid = 1'b1; tick();
        b_in_valid = 1'b0; tick();
        b_out_valid = 1'b1; b_out = 32'h40A00000;
        tick();
        chk("b_pre_rst_ok", 32'(b_err_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("b_rst_err_code",  32'(b_err_code),  32'd0);
        chk("b_rst_err_valid", 32'(b_err_valid), 32'd0);
        chk("a_rst_pat_cnt",   32'(a_pat_cnt),   32'd0);
        chk("a_rst_fail_cnt",  32'(a_fail_cnt),  32'd0);
        b_out_valid = 1'b0; b_out = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // B: clean 4-word pattern after reset
        b_gold_valid = 1'b1;
        b_gold_data = 32'h3F800000; tick();
        b_gold_data = 32'h40000000; tick();
        b_gold_data = 32'h40400000; tick();
        b_gold_data = 32'h40800000; tick();
        b_gold_valid = 1'b0;
        b_in_valid = 1'b1; tick();
        b_in_valid = 1'b0; tick();
        tick();
        b_out_valid = 1'b1;
        b_out = 32'h3F800000; tick();
        b_out = 32'h40000000; tick();
        b_out = 32'h40400001; tick();
        b_out = 32'h40800000; tick();
        b_out_valid = 1'b0; b_out = '0;
        chk("b_clean_pat_done",  32'(b_pat_done),  32'd1);
        chk("b_clean_pat_cnt",   32'(b_pat_cnt),   32'd1);
        chk("b_clean_err_code",  32'(b_err_code),  32'd0);
        chk("b_clean_fail_cnt",  32'(b_fail_cnt),  32'd0);
        tick();

        // C: depth-2 queue overflow then a 3-word burst
        c_gold_valid = 1'b1;
        c_gold_data = 32'h3F800000; tick();
        chk("c_full_after_1", 32'(c_gold_full), 32'd0);
        c_gold_data = 32'h40000000; tick();
        chk("c_full_after_2", 32'(c_gold_full), 32'd1);
        c_gold_data = 32'h40400000; tick();
        chk("c_full_after_3", 32'(c_gold_full), 32'd1);
        chk("c_drop_no_err",  32'(c_err_valid), 32'd0);
        c_gold_valid = 1'b0;
        c_in_valid = 1'b1; tick();
        c_in_valid = 1'b0; tick();
        c_out_valid = 1'b1;
        c_out = 32'h3F800000; tick();
        chk("c_w1_err_valid", 32'(c_err_valid), 32'd0);
        chk("c_w1_full_clr",  32'(c_gold_full), 32'd0);
        c_out = 32'h40000000; tick();
        chk("c_w2_err_valid", 32'(c_err_valid), 32'd0);
        c_out = 32'h40400000; tick();
        c_out_valid = 1'b0; c_out = '0;
        chk("c_w3_err_valid", 32'(c_err_valid), 32'd1);
        chk("c_w3_err_code",  32'(c_err_code),  32'd7);
        chk("c_w3_fail_cnt",  32'(c_fail_cnt),  32'd0);
        chk("c_w3_pat_done",  32'(c_pat_done),  32'd1);
        chk("c_w3_pat_cnt",   32'(c_pat_cnt),   32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
